circulant_transpose_ctrl: RTL and testbench
===========================================

// Module: circulant_transpose_ctrl
// PURPOSE
//   Streaming transpose engine built around an N-bank circulant matrix store.
//   Accepts one NxN matrix element per cycle in row-major order. Writes each element
//   into bank (row+col) mod N at address row. After the full matrix is stored, emits
//   it in column-major order (the transpose), one element per cycle, with valid/ready
//   backpressure. Sits between a row-major producer and a column-consuming datapath.
// PARAMETERS
//   N   4  matrix dimension / number of banks; power of two, >=2
//   DW  8  element width in bits
// PORTS
//   clk        in   1         single clock, all logic on posedge
//   rst_n      in   1         asynchronous, active-low reset
//   in_data    in   DW        input element, row-major order
//   in_valid   in   1         in_data valid
//   in_ready   out  1         controller accepts in_data this cycle
//   out_data   out  DW        transposed element, column-major order
//   out_valid  out  1         out_data valid
//   out_ready  in   1         consumer accepts out_data
//   out_last   out  1         qualifies the final element of a matrix (with out_valid)
//   busy       out  1         high while in DRAIN state
// BEHAVIOUR
//   - Reset (async assert, sync deassert internally):
//     state=FILL, wr_cnt=0, rd_cnt=0, out_valid=0, out_last=0, busy=0.
//     Bank contents are NOT cleared.
//   - Counters are log2(N*N) bits. Write address: row=wr_cnt[hi], col=wr_cnt[lo].
//     Read order: col=rd_cnt[hi], row=rd_cnt[lo]. Bank select=(row+col) mod N,
//     truncated add, wraps naturally.
//   - FILL: in_ready=1. Each in_valid&in_ready writes one bank entry and increments
//     wr_cnt. Gaps in in_valid stall the counter only. The write of element N*N-1
//     moves the controller to DRAIN next cycle and clears wr_cnt.
//   - DRAIN: in_ready=0, busy=1. A read is issued when rd_cnt<N*N and
//     (!out_valid || out_ready). Bank read is synchronous: out_data/out_valid appear
//     exactly 1 cycle after issue. Issue increments rd_cnt.
//   - Stall: while out_valid && !out_ready, no read is issued. The bank output
//     register holds, so out_data is stable.
//   - Throughput: 1 element/cycle in both phases when unstalled. First out_valid
//     appears 2 cycles after the final input handshake.
//   - out_last=1 with the element read at rd_cnt=N*N-1. The handshake of that element
//     returns the controller to FILL and clears rd_cnt. in_ready is high the same
//     cycle as that transfer; the new matrix overlaps only the final handshake.
//   - out_valid falls after the final handshake unless a new read is pending (none
//     in FILL).
//   - Reset mid-FILL or mid-DRAIN abandons the matrix; the next input is element 0.
//   - No write and read ever target the same bank in one cycle (phases exclusive).
// STRUCTURE
//   - Shared package circ_pkg: function circ_bank(row, col) = (row+col) mod N,
//     state encoding localparams ST_FILL, ST_DRAIN, clog2 helper.
//   - Sub-module circ_bank_mem (DW x N, 1 write port, 1 sync read port, read-enable
//     gates output register), instantiated N times via generate.
//   - Top level holds the FSM, counters, bank-select decode/mux, and output valid
//     pipeline.
// TESTING
//   1 N=4, feed 0..15 row-major, out_ready=1
//     -> out 0,4,8,12,1,5,9,13,2,6,10,14,3,7,11,15; out_last only on 15.
//   2 Same, out_ready toggling 1010..
//     -> same sequence, no drop/duplicate, out_data stable while stalled.
//   3 in_valid with random gaps (50%)
//     -> identical output; DRAIN entered only after the 16th accepted input.
//   4 Two back-to-back matrices (0..15, then 100..115)
//     -> in_ready=0 for all of DRAIN; second output 100,104,...,115.
//   5 Assert rst_n low mid-DRAIN after 5 outputs
//     -> out_valid=0 immediately, in_ready=1 after release; a fresh matrix transposes
//        correctly.
//   6 N=8, DW=16, elements r*8+c
//     -> output order c*8+r for c=0..7, r=0..7; busy high for exactly the drain
//        duration.

Source files
------------

// File: rtl/circ_pkg.sv
// Shared definitions for the circulant transpose engine: FSM states,
// a constant-foldable clog2 and the circulant bank mapping.
package circ_pkg;

    typedef enum logic {
        ST_FILL  = 1'b0,
        ST_DRAIN = 1'b1
    } state_e;

    function automatic int circ_clog2(input int value);
        int r;
        r = 0;
        while ((1 << r) < value) r++;
        return r;
    endfunction

    // Element (row, col) lives in bank (row + col) mod n at address row.
    function automatic int unsigned circ_bank(input int unsigned row,
                                              input int unsigned col,
                                              input int unsigned n);
        return (row + col) % n;
    endfunction

endpackage

// File: rtl/circulant_transpose_ctrl_if.sv
// Producer/consumer stream bundle of the transpose engine; master is the
// environment side, slave is the engine side.
interface circulant_transpose_ctrl_if #(
    parameter int DW = 8
);
    logic [DW-1:0] in_data;
    logic          in_valid;
    logic          in_ready;
    logic [DW-1:0] out_data;
    logic          out_valid;
    logic          out_ready;
    logic          out_last;
    logic          busy;

    modport master (
        output in_data, in_valid, out_ready,
        input  in_ready, out_data, out_valid, out_last, busy
    );

    modport slave (
        input  in_data, in_valid, out_ready,
        output in_ready, out_data, out_valid, out_last, busy
    );
endinterface

// File: rtl/circ_bank_mem.sv
// One circulant bank: single write port, synchronous read port whose output
// register only updates on a read enable, so it holds while the consumer stalls.
module circ_bank_mem
    import circ_pkg::*;
#(
    parameter int DW    = 8,
    parameter int DEPTH = 4,
    parameter int AW    = circ_clog2(DEPTH)
) (
    input  logic          clk,
    input  logic          we_i,
    input  logic [AW-1:0] waddr_i,
    input  logic [DW-1:0] wdata_i,
    input  logic          re_i,
    input  logic [AW-1:0] raddr_i,
    output logic [DW-1:0] rdata_o
);
    logic [DW-1:0] mem_q [DEPTH];
    logic [DW-1:0] rdata_q;

    // NOTE: storage has no reset; contents are always written before they are read.
    always_ff @(posedge clk) begin
        if (we_i) mem_q[waddr_i] <= wdata_i;
        if (re_i) rdata_q <= mem_q[raddr_i];
    end

    assign rdata_o = rdata_q;
endmodule

// File: rtl/circulant_transpose_ctrl.sv
// Streaming NxN transpose: row-major elements fill a circulant bank store,
// then drain column-major with valid/ready backpressure.
module circulant_transpose_ctrl
    import circ_pkg::*;
#(
    parameter int N  = 4,
    parameter int DW = 8
) (
    input logic                       clk,
    input logic                       rst_n,
    circulant_transpose_ctrl_if.slave bus
);
    localparam int LW   = circ_clog2(N);
    localparam int CW   = 2 * LW;
    localparam int LAST = N * N - 1;

    logic [1:0] rst_sync_q;
    logic       rst_n_s;

    state_e        state_q, state_d;
    logic [CW-1:0] wr_cnt_q, wr_cnt_d;
    logic [CW:0]   rd_cnt_q, rd_cnt_d;   // extra MSB marks "all N*N reads issued"
    logic          out_valid_q, out_valid_d;
    logic          out_last_q, out_last_d;
    logic [LW-1:0] sel_q, sel_d;

    logic          in_ready, wr_fire, rd_fire, last_fire;
    logic [LW-1:0] wr_row, wr_col, rd_row, rd_col, wr_bank;
    logic [N-1:0]  bank_we, bank_re;
    logic [DW-1:0] bank_rdata [N];

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) rst_sync_q <= '0;
        else        rst_sync_q <= {rst_sync_q[0], 1'b1};
    end
    assign rst_n_s = rst_sync_q[1];

    assign wr_row  = wr_cnt_q[CW-1:LW];
    assign wr_col  = wr_cnt_q[LW-1:0];
    assign rd_col  = rd_cnt_q[CW-1:LW];
    assign rd_row  = rd_cnt_q[LW-1:0];
    assign wr_bank = LW'(circ_bank(32'(wr_row), 32'(wr_col), N));

    assign last_fire = out_valid_q && bus.out_ready && out_last_q;
    assign in_ready  = (state_q == ST_FILL) || last_fire;
    assign wr_fire   = bus.in_valid && in_ready;
    assign rd_fire   = (state_q == ST_DRAIN) && !rd_cnt_q[CW] && (!out_valid_q || bus.out_ready);

    // NOTE: combinational next-state uses blocking assignments, every target defaulted first so no latch is inferred.
    always_comb begin
        state_d     = state_q;
        wr_cnt_d    = wr_cnt_q;
        rd_cnt_d    = rd_cnt_q;
        out_valid_d = out_valid_q;
        out_last_d  = out_last_q;
        sel_d       = sel_q;

        if (wr_fire) begin
            if (wr_cnt_q == CW'(LAST)) begin
                wr_cnt_d = '0;
                state_d  = ST_DRAIN;
            end else begin
                wr_cnt_d = wr_cnt_q + CW'(1);
            end
        end

        if (bus.out_ready) begin
            out_valid_d = 1'b0;
            out_last_d  = 1'b0;
        end

        if (rd_fire) begin
            out_valid_d = 1'b1;
            out_last_d  = (rd_cnt_q[CW-1:0] == CW'(LAST));
            sel_d       = LW'(circ_bank(32'(rd_row), 32'(rd_col), N));
            rd_cnt_d    = rd_cnt_q + (CW + 1)'(1);
        end

        if (last_fire) begin
            state_d  = ST_FILL;
            rd_cnt_d = '0;
        end
    end

    // NOTE: sequential state uses non-blocking assignments only.
    always_ff @(posedge clk or negedge rst_n_s) begin
        if (!rst_n_s) begin
            state_q     <= ST_FILL;
            wr_cnt_q    <= '0;
            rd_cnt_q    <= '0;
            out_valid_q <= 1'b0;
            out_last_q  <= 1'b0;
            sel_q       <= '0;
        end else begin
            state_q     <= state_d;
            wr_cnt_q    <= wr_cnt_d;
            rd_cnt_q    <= rd_cnt_d;
            out_valid_q <= out_valid_d;
            out_last_q  <= out_last_d;
            sel_q       <= sel_d;
        end
    end

    for (genvar i = 0; i < N; i++) begin : g_bank
        assign bank_we[i] = wr_fire && (wr_bank == LW'(i));
        assign bank_re[i] = rd_fire && (LW'(circ_bank(32'(rd_row), 32'(rd_col), N)) == LW'(i));

        circ_bank_mem #(
            .DW   (DW),
            .DEPTH(N)
        ) u_mem (
            .clk    (clk),
            .we_i   (bank_we[i]),
            .waddr_i(wr_row),
            .wdata_i(bus.in_data),
            .re_i   (bank_re[i]),
            .raddr_i(rd_row),
            .rdata_o(bank_rdata[i])
        );
    end

    assign bus.in_ready  = in_ready;
    assign bus.out_data  = bank_rdata[sel_q];
    assign bus.out_valid = out_valid_q;
    assign bus.out_last  = out_last_q;
    assign bus.busy      = (state_q == ST_DRAIN);
endmodule

// File: tb/tb_circulant_transpose_ctrl.sv
// Scoreboard bench for the circulant transpose engine: an N=4/DW=8 and an
// N=8/DW=16 instance share one stimulus path selected by use8.
module tb_circulant_transpose_ctrl;

    typedef struct {
        logic [15:0] data;
        logic        last;
    } exp_t;

    logic        clk, rst_n, use8;
    logic        in_valid, out_ready;
    logic [15:0] in_data;
    logic        in_ready, out_valid, out_last, busy;
    logic [15:0] out_data;
    int          rdy_mode;

    int   n_checks, n_fail, out_count, busy_cycles;
    exp_t exp_q[$];
    exp_t mon_e;
    logic        stall_pend;
    logic [15:0] held_data;

    circulant_transpose_ctrl_if #(.DW(8))  if4 ();
    circulant_transpose_ctrl_if #(.DW(16)) if8 ();

    assign if4.in_valid  = in_valid & ~use8;
    assign if4.in_data   = in_data[7:0];
    assign if4.out_ready = out_ready;
    assign if8.in_valid  = in_valid & use8;
    assign if8.in_data   = in_data;
    assign if8.out_ready = out_ready;

    assign in_ready  = use8 ? if8.in_ready  : if4.in_ready;
    assign out_valid = use8 ? if8.out_valid : if4.out_valid;
    assign out_last  = use8 ? if8.out_last  : if4.out_last;
    assign busy      = use8 ? if8.busy      : if4.busy;
    assign out_data  = use8 ? if8.out_data  : {8'h00, if4.out_data};

    circulant_transpose_ctrl #(.N(4), .DW(8)) u_dut4 (
        .clk  (clk),
        .rst_n(rst_n),
        .bus  (if4.slave)
    );

    circulant_transpose_ctrl #(.N(8), .DW(16)) u_dut8 (
        .clk  (clk),
        .rst_n(rst_n),
        .bus  (if8.slave)
    );

    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    initial begin
        #5_000_000;
        $display("FAIL watchdog: simulation did not finish, checks=%0d", n_checks);
        $fatal(1, "watchdog expired");
    end

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", tag, got, exp, $time);
        end
    endtask

    // Consumer ready pattern: 0 always ready, 1 alternating, 2 random.
    initial begin
        out_ready = 1'b1;
        forever begin
            @(posedge clk);
            #1;
            case (rdy_mode)
                0:       out_ready = 1'b1;
                1:       out_ready = ~out_ready;
                default: out_ready = 1'($urandom_range(1));
            endcase
        end
    end

    // Output monitor: compares every transfer against the scoreboard and
    // checks stall stability and input blocking during drain.
    always @(negedge clk) begin
        if (!rst_n) begin
            stall_pend = 1'b0;
        end else begin
            if (stall_pend) begin
                check("stall_valid", 32'(out_valid), 32'd1);
                check("stall_data", 32'(out_data), 32'(held_data));
            end
            if (busy) busy_cycles++;
            if (busy && !(out_valid && out_ready && out_last))
                check("drain_in_ready", 32'(in_ready), 32'd0);
            if (out_valid && out_ready) begin
                check("sb_nonempty", 32'(exp_q.size() != 0), 32'd1);
                if (exp_q.size() != 0) begin
                    mon_e = exp_q.pop_front();
                    check("out_data", 32'(out_data), 32'(mon_e.data));
                    check("out_last", 32'(out_last), 32'(mon_e.last));
                    out_count++;
                end
            end
            stall_pend = out_valid && !out_ready;
            held_data  = out_data;
        end
    end

    task automatic send_matrix(input int base, input int gap_pct);
        int   n;
        exp_t e;
        n = use8 ? 8 : 4;
        for (int c = 0; c < n; c++) begin
            for (int r = 0; r < n; r++) begin
                e.data = 16'(base + r * n + c);
                e.last = (c == n - 1) && (r == n - 1);
                exp_q.push_back(e);
            end
        end
        for (int k = 0; k < n * n; k++) begin
            int wait_cyc;
            bit done;
            wait_cyc = 0;
            done     = 1'b0;
            while (!done) begin
                @(posedge clk);
                #1;
                in_valid = (int'($urandom_range(99)) >= gap_pct);
                in_data  = 16'(base + k);
                @(negedge clk);
                if (in_valid && in_ready) begin
                    done = 1'b1;
                    if (k > 0) check("fill_busy", 32'(busy), 32'd0);
                end else if (++wait_cyc > 300) begin
                    check("in_ready_timeout", 32'(in_ready), 32'd1);
                    in_valid = 1'b0;
                    return;
                end
            end
        end
        @(posedge clk);
        #1;
        in_valid = 1'b0;
        @(negedge clk);
        check("drain_entry_busy", 32'(busy), 32'd1);
        check("latency_valid_lo", 32'(out_valid), 32'd0);
        @(negedge clk);
        check("latency_valid_hi", 32'(out_valid), 32'd1);
    endtask

    task automatic wait_drain();
        for (int i = 0; i < 2000 && exp_q.size() != 0; i++) @(negedge clk);
        check("drain_done", 32'(exp_q.size()), 32'd0);
        @(posedge clk);
        @(negedge clk);
        check("idle_valid", 32'(out_valid), 32'd0);
        check("idle_busy", 32'(busy), 32'd0);
        check("idle_in_ready", 32'(in_ready), 32'd1);
    endtask

    initial begin
        int cnt0;
        n_checks    = 0;
        n_fail      = 0;
        out_count   = 0;
        busy_cycles = 0;
        rst_n       = 1'b0;
        use8        = 1'b0;
        in_valid    = 1'b0;
        in_data     = '0;
        rdy_mode    = 0;
        stall_pend  = 1'b0;
        held_data   = '0;

        repeat (4) @(posedge clk);
        @(negedge clk);
        check("rst_in_ready", 32'(in_ready), 32'd1);
        check("rst_out_valid", 32'(out_valid), 32'd0);
        check("rst_out_last", 32'(out_last), 32'd0);
        check("rst_busy", 32'(busy), 32'd0);
        check("rst8_out_valid", 32'(if8.out_valid), 32'd0);
        check("rst8_busy", 32'(if8.busy), 32'd0);
        rst_n = 1'b1;
        repeat (3) @(posedge clk);

        // Plain transpose, consumer always ready
        send_matrix(0, 0);
        wait_drain();

        // Alternating backpressure
        rdy_mode = 1;
        send_matrix(0, 0);
        wait_drain();

        // Producer gaps
        rdy_mode = 0;
        send_matrix(0, 50);
        wait_drain();

        // Back-to-back matrices under random backpressure
        rdy_mode = 2;
        send_matrix(0, 0);
        send_matrix(100, 0);
        wait_drain();

        // Reset in the middle of a drain
        rdy_mode = 0;
        @(posedge clk);
        #1;
        cnt0 = out_count;
        send_matrix(50, 0);
        for (int i = 0; i < 200 && out_count < cnt0 + 5; i++) @(negedge clk);
        check("mid_drain_reached", 32'(out_count >= cnt0 + 5), 32'd1);
        #2;
        rst_n = 1'b0;
        #1;
        check("mid_rst_out_valid", 32'(out_valid), 32'd0);
        check("mid_rst_busy", 32'(busy), 32'd0);
        check("mid_rst_in_ready", 32'(in_ready), 32'd1);
        exp_q.delete();
        repeat (2) @(posedge clk);
        @(negedge clk);
        rst_n = 1'b1;
        repeat (3) @(posedge clk);
        @(negedge clk);
        check("post_rst_in_ready", 32'(in_ready), 32'd1);
        send_matrix(200, 0);
        wait_drain();

        // N=8 instance, busy must span exactly the drain
        use8 = 1'b1;
        @(posedge clk);
        #1;
        busy_cycles = 0;
        send_matrix(0, 0);
        wait_drain();
        check("busy_duration8", 32'(busy_cycles), 32'd65);

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
